// File: rtl/axi_b2as_pkg.sv
// Shared types and helpers for the BRAM->AXIS engine scheduler.
// Optional statistics are enabled with the AXI_B2AS_SCHED_STATS_EN macro (see axi_b2as_sched).
package axi_b2as_pkg;

    // Scheduler control states
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_REJECT    = 3'd4
    } state_e;

    // Default engine beat geometry
    localparam int unsigned BRAM_DATA_WIDTH_DEF = 512;
    localparam int unsigned BYTES_PER_BEAT      = BRAM_DATA_WIDTH_DEF / 8;

    // Bytes carried by one beat of a given data width
    function automatic int unsigned bytes_per_beat(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Bank-select width: at least one bit even for tiny requester counts
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // A transfer is legal when it spans at least one beat and fits the engine address range
    function automatic logic depth_legal(input logic [63:0] depth, input int unsigned addr_w);
        logic [63:0] max_depth;
        if (addr_w >= 64) begin
            max_depth = {64{1'b1}};
        end else begin
            max_depth = (64'd1 << addr_w) - 64'd1;
        end
        return (depth != 64'd0) && (depth <= max_depth);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter
    import axi_b2as_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned SEL_W  = sel_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_c_o,
    output logic [SEL_W-1:0]   idx_c_o,
    output logic               valid_c_o
);

    // Scan from the pointer; the first hit wins, later hits are masked by valid_c_o
    always_comb begin
        int unsigned k;
        gnt_c_o   = '0;
        idx_c_o   = '0;
        valid_c_o = 1'b0;
        k         = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr_i) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!valid_c_o && req_i[k]) begin
                valid_c_o  = 1'b1;
                gnt_c_o[k] = 1'b1;
                idx_c_o    = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/axi_b2as_sched.sv
// Round-robin scheduler sharing one axi_bram2axis engine among NUM_REQ BRAM banks.
// Define AXI_B2AS_SCHED_STATS_EN to add per-requester completed-transfer counters (o_xfer_cnt).
module axi_b2as_sched
    import axi_b2as_pkg::*;
#(
    parameter int unsigned NUM_REQ             = 4,
    parameter int unsigned AXI_XFER_SIZE_WIDTH = 32,
    parameter int unsigned BRAM_ADDR_WIDTH     = 32,
    parameter int unsigned BRAM_DATA_WIDTH     = 512,
    localparam int unsigned SEL_W              = sel_width(NUM_REQ)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     i_req,
    input  logic [NUM_REQ*AXI_XFER_SIZE_WIDTH-1:0] i_req_size_bytes,
    output logic [NUM_REQ-1:0]                     o_ack,
    output logic [NUM_REQ-1:0]                     o_done,
    output logic [NUM_REQ-1:0]                     o_err,
    output logic                                   o_busy,
    output logic [SEL_W-1:0]                       o_bank_sel,
    output logic                                   o_b2as_start,
    output logic [AXI_XFER_SIZE_WIDTH-1:0]         o_b2as_data_size_bytes,
`ifdef AXI_B2AS_SCHED_STATS_EN
    output logic [NUM_REQ*32-1:0]                  o_xfer_cnt,
`endif
    input  logic                                   i_b2as_done
);

    // Depth is evaluated 3 bits wider so size*8 cannot overflow
    localparam int unsigned DEPTH_W = AXI_XFER_SIZE_WIDTH + 3;

    state_e                         state_q;
    logic [SEL_W-1:0]               ptr_q;
    logic [SEL_W-1:0]               gnt_q;
    logic [NUM_REQ-1:0]             ack_q;
    logic [NUM_REQ-1:0]             done_q;
    logic [NUM_REQ-1:0]             err_q;
    logic                           start_q;
    logic                           busy_q;
    logic [AXI_XFER_SIZE_WIDTH-1:0] size_q;

    logic [NUM_REQ-1:0]             arb_gnt_c;
    logic [SEL_W-1:0]               arb_idx_c;
    logic                           arb_vld_c;
    logic [AXI_XFER_SIZE_WIDTH-1:0] win_size_d;
    logic [DEPTH_W-1:0]             depth_d;
    logic                           legal_d;
    logic                           grant_go_d;
    logic [NUM_REQ-1:0]             gnt_oh_d;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_arb (
        .req_i     (i_req),
        .ptr_i     (ptr_q),
        .gnt_c_o   (arb_gnt_c),
        .idx_c_o   (arb_idx_c),
        .valid_c_o (arb_vld_c)
    );

    // Select the winner's size slot from the packed size bus
    always_comb begin
        win_size_d = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (arb_idx_c == SEL_W'(k)) begin
                win_size_d = i_req_size_bytes[k*AXI_XFER_SIZE_WIDTH +: AXI_XFER_SIZE_WIDTH];
            end
        end
    end

    // Beat count of the candidate; sub-beat remainders are left to the engine to truncate
    assign depth_d    = (DEPTH_W'(win_size_d) << 3) / DEPTH_W'(BRAM_DATA_WIDTH);
    assign legal_d    = depth_legal(64'(depth_d), BRAM_ADDR_WIDTH);
    assign grant_go_d = arb_vld_c && i_b2as_done;
    assign gnt_oh_d   = NUM_REQ'(1) << gnt_q;

    // Round-robin successor of a granted index
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] g);
        if (int'(g) >= int'(NUM_REQ) - 1) begin
            return '0;
        end
        return g + SEL_W'(1);
    endfunction

    // Control FSM with registered pulses; idle arbitration waits for the engine to be idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            size_q  <= '0;
        end else begin
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (grant_go_d) begin
                        gnt_q  <= arb_idx_c;
                        size_q <= win_size_d;
                        ack_q  <= arb_gnt_c;
                        busy_q <= 1'b1;
                        if (legal_d) begin
                            start_q <= 1'b1;
                            state_q <= S_ISSUE;
                        end else begin
                            done_q  <= arb_gnt_c;
                            err_q   <= arb_gnt_c;
                            ptr_q   <= next_ptr(arb_idx_c);
                            state_q <= S_REJECT;
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!i_b2as_done) begin
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (i_b2as_done) begin
                        done_q  <= gnt_oh_d;
                        ptr_q   <= next_ptr(gnt_q);
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_REJECT: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ack                  = ack_q;
    assign o_done                 = done_q;
    assign o_err                  = err_q;
    assign o_busy                 = busy_q;
    assign o_bank_sel             = gnt_q;
    assign o_b2as_start           = start_q;
    assign o_b2as_data_size_bytes = size_q;

`ifdef AXI_B2AS_SCHED_STATS_EN
    logic [31:0] cnt_q [NUM_REQ];

    // Count completions that were not rejects; free-running wrap at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (done_q[k] && !err_q[k]) begin
                    cnt_q[k] <= cnt_q[k] + 32'd1;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
        assign o_xfer_cnt[k*32 +: 32] = cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_axi_b2as_sched.sv
// Randomized and directed bench for axi_b2as_sched against a transaction-timing model.
module tb_axi_b2as_sched;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int AW = 32;
    localparam int DW = 512;

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic [N-1:0]     req_v      = '0;
    logic [N*W-1:0]   size_v     = '0;
    logic             eng_done_v = 1'b1;

    logic [N-1:0]     o_ack, o_done, o_err;
    logic             o_busy;
    logic [1:0]       o_bank_sel;
    logic             o_b2as_start;
    logic [W-1:0]     o_size;
`ifdef AXI_B2AS_SCHED_STATS_EN
    logic [N*32-1:0]  o_xfer_cnt;
    logic [31:0]      m_cnt [N];
`endif

    axi_b2as_sched #(
        .NUM_REQ             (N),
        .AXI_XFER_SIZE_WIDTH (W),
        .BRAM_ADDR_WIDTH     (AW),
        .BRAM_DATA_WIDTH     (DW)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .i_req                  (req_v),
        .i_req_size_bytes       (size_v),
        .o_ack                  (o_ack),
        .o_done                 (o_done),
        .o_err                  (o_err),
        .o_busy                 (o_busy),
        .o_bank_sel             (o_bank_sel),
        .o_b2as_start           (o_b2as_start),
        .o_b2as_data_size_bytes (o_size),
`ifdef AXI_B2AS_SCHED_STATS_EN
        .o_xfer_cnt             (o_xfer_cnt),
`endif
        .i_b2as_done            (eng_done_v)
    );

    always #5 clk = ~clk;

    // stimulus commands (applied inside step)
    logic         rst_cmd     = 1'b1;
    logic [N-1:0] raise_mask  = '0;
    logic [N-1:0] rerais_mask = '0;
    logic [W-1:0] size_cmd [N];
    logic [W-1:0] size_r   [N];
    int           drop_cyc [N];
    int           req_cyc  [N];
    bit           rnd_mode = 1'b0;
    bit           eng_hold = 1'b0;
    int           eng_left = 0;
    logic         eng_prev = 1'b1;
    int           eng_rise_cyc = -1;

    // model state: scheduler seen as "free / one transaction in flight"
    int           cyc = 0;
    int           m_ptr = 0;
    bit           m_active = 1'b0;
    int           m_owner = 0;
    int           m_issue_at = 0;
    bit           m_low_seen = 1'b0;
    int           m_free_at = 0;
    logic [N-1:0] e_ack = '0, e_done = '0, e_err = '0;
    logic         e_start = 1'b0, e_busy = 1'b0;
    int           e_sel = 0;
    logic [W-1:0] e_size = '0;

    // observation logs
    int           obs_ack[$];
    int           obs_ack_cyc[$];
    int           obs_err[$];
    int           n_start = 0, n_good_done = 0;
    int           last_start_cyc = -1, last_done_cyc = -1, last_start_sel = 0;
    logic [W-1:0] last_start_size = '0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            int k = (p + i) % N;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rnd_size();
        case ($urandom_range(0, 3))
            0:       return W'($urandom_range(0, 63));
            1:       return W'($urandom_range(1, 64) * 64);
            2:       return W'($urandom);
            default: return W'($urandom_range(64, 5000));
        endcase
    endfunction

    // Predict outputs of the next cycle from this cycle's inputs
    task automatic model_step();
        logic [63:0] depth;
        int g;
        e_ack = '0; e_done = '0; e_err = '0; e_start = 1'b0;
        if (rst) begin
            m_ptr = 0; m_active = 1'b0; m_free_at = 0;
            e_sel = 0; e_size = '0; e_busy = 1'b0;
            return;
        end
        if (m_active) begin
            if (cyc > m_issue_at) begin
                if (!m_low_seen) begin
                    if (!eng_done_v) m_low_seen = 1'b1;
                end else if (eng_done_v) begin
                    e_done[m_owner] = 1'b1;
                    m_ptr = (m_owner + 1) % N;
                    m_active = 1'b0;
                end
            end
        end else if (cyc >= m_free_at && req_v != '0 && eng_done_v) begin
            g = rr_pick(req_v, m_ptr);
            e_sel  = g;
            e_size = size_v[g*W +: W];
            depth  = (64'(e_size) * 64'd8) / 64'(DW);
            e_ack[g] = 1'b1;
            if (depth >= 64'd1 && depth <= ((64'd1 << AW) - 64'd1)) begin
                e_start = 1'b1;
                m_active = 1'b1; m_owner = g; m_issue_at = cyc + 1; m_low_seen = 1'b0;
            end else begin
                e_done[g] = 1'b1; e_err[g] = 1'b1;
                m_ptr = (g + 1) % N;
                m_free_at = cyc + 2;
            end
        end
        e_busy = m_active || (cyc + 1 < m_free_at);
    endtask

    // One clock: compare, react as requesters/engine, drive inputs, advance model
    task automatic step();
        bit rnd_rst;
        @(negedge clk);
        chk("ack",      64'(o_ack),        64'(e_ack));
        chk("done",     64'(o_done),       64'(e_done));
        chk("err",      64'(o_err),        64'(e_err));
        chk("start",    64'(o_b2as_start), 64'(e_start));
        chk("busy",     64'(o_busy),       64'(e_busy));
        chk("bank_sel", 64'(o_bank_sel),   64'(e_sel));
        chk("size",     64'(o_size),       64'(e_size));
`ifdef AXI_B2AS_SCHED_STATS_EN
        for (int k = 0; k < N; k++) begin
            chk("xfer_cnt", 64'(o_xfer_cnt[k*32 +: 32]), 64'(m_cnt[k]));
            if (e_done[k] && !e_err[k]) m_cnt[k] = m_cnt[k] + 32'd1;
        end
`endif
        for (int k = 0; k < N; k++) begin
            if (o_ack[k]) begin
                obs_ack.push_back(k);
                obs_ack_cyc.push_back(cyc);
                req_v[k] = 1'b0;
                drop_cyc[k] = cyc;
                if (rerais_mask[k]) raise_mask[k] = 1'b1;
            end
            if (o_err[k]) obs_err.push_back(k);
            if (o_done[k] && !o_err[k]) begin
                n_good_done++;
                last_done_cyc = cyc;
            end
        end
        if (o_b2as_start) begin
            n_start++;
            last_start_cyc  = cyc;
            last_start_sel  = int'(o_bank_sel);
            last_start_size = o_size;
        end
        for (int k = 0; k < N; k++) begin
            if (!req_v[k] && cyc > drop_cyc[k]) begin
                if (raise_mask[k]) begin
                    raise_mask[k] = 1'b0;
                    req_v[k] = 1'b1; size_r[k] = size_cmd[k]; req_cyc[k] = cyc;
                end else if (rnd_mode && $urandom_range(0, 3) == 0) begin
                    req_v[k] = 1'b1; size_r[k] = rnd_size(); req_cyc[k] = cyc;
                end
            end
            size_v[k*W +: W] = size_r[k];
        end
        if (eng_left > 0) begin
            eng_done_v = 1'b0;
            eng_left--;
        end else begin
            eng_done_v = !eng_hold;
        end
        if (o_b2as_start) eng_left = $urandom_range(1, 4);
        if (eng_done_v && !eng_prev) eng_rise_cyc = cyc;
        eng_prev = eng_done_v;
        rnd_rst = rnd_mode && ($urandom_range(0, 599) == 0);
        rst = rst_cmd || rnd_rst;
`ifdef AXI_B2AS_SCHED_STATS_EN
        if (rst) for (int k = 0; k < N; k++) m_cnt[k] = '0;
`endif
        model_step();
        cyc++;
    endtask

    task automatic do_reset();
        rst_cmd = 1'b1;
        repeat (2) step();
        rst_cmd = 1'b0;
        step();
    endtask

    task automatic clear_logs();
        obs_ack.delete(); obs_ack_cyc.delete(); obs_err.delete();
    endtask

    task automatic wait_acks(input int want, input int budget, input string nm);
        int k = 0;
        while (obs_ack.size() < want && k < budget) begin
            step();
            k++;
        end
        chk(nm, 64'(obs_ack.size() >= want), 64'd1);
    endtask

    task automatic drain(input string nm);
        int k = 0;
        while ((m_active || req_v != '0 || raise_mask != '0 || cyc < m_free_at) && k < 400) begin
            step();
            k++;
        end
        chk(nm, 64'(k < 400), 64'd1);
        repeat (2) step();
    endtask

    initial begin
        int ns, nd, base;
        for (int k = 0; k < N; k++) begin
            size_cmd[k] = '0; size_r[k] = '0; drop_cyc[k] = -1; req_cyc[k] = -1;
`ifdef AXI_B2AS_SCHED_STATS_EN
            m_cnt[k] = '0;
`endif
        end

        // reset state
        repeat (3) step();
        chk("rst_busy",  64'(o_busy), 64'd0);
        chk("rst_ack",   64'(o_ack),  64'd0);
        rst_cmd = 1'b0;
        step();

        // single request on bank 1, 256 B = 4 beats
        clear_logs();
        size_cmd[1] = 32'd256;
        raise_mask  = 4'b0010;
        wait_acks(1, 20, "t1_ack_wait");
        drain("t1_drain");
        chk("t1_ack_idx",   64'(obs_ack[0]), 64'd1);
        chk("t1_ack_lat",   64'(obs_ack_cyc[0] - req_cyc[1]), 64'd1);
        chk("t1_start_lat", 64'(last_start_cyc - req_cyc[1]), 64'd1);
        chk("t1_sel",       64'(last_start_sel), 64'd1);
        chk("t1_size",      64'(last_start_size), 64'd256);
        chk("t1_done_lat",  64'(last_done_cyc - eng_rise_cyc), 64'd1);
        chk("t1_no_err",    64'(obs_err.size()), 64'd0);

        // all four at once from reset: 0,1,2,3 then pointer back at 0
        do_reset();
        clear_logs();
        for (int k = 0; k < N; k++) size_cmd[k] = 32'd256;
        raise_mask = 4'b1111;
        wait_acks(4, 200, "t2_wait");
        for (int i = 0; i < 4; i++) chk("t2_order", 64'(obs_ack[i]), 64'(i));
        raise_mask = 4'b1111;
        wait_acks(5, 100, "t2_wait2");
        chk("t2_wrap", 64'(obs_ack[4]), 64'd0);
        drain("t2_drain");

        // starvation: req[0] keeps coming back while req[2] waits
        do_reset();
        clear_logs();
        size_cmd[0] = 32'd512; size_cmd[2] = 32'd512;
        rerais_mask = 4'b0001;
        raise_mask  = 4'b0101;
        wait_acks(3, 200, "t3_wait");
        rerais_mask = '0;
        raise_mask  = '0;
        chk("t3_first",  64'(obs_ack[0]), 64'd0);
        chk("t3_second", 64'(obs_ack[1]), 64'd2);
        chk("t3_third",  64'(obs_ack[2]), 64'd0);
        drain("t3_drain");

        // 32 B is zero beats: reject on bank 3, then bank 1 served normally
        clear_logs();
        ns = n_start;
        size_cmd[3] = 32'd32;
        raise_mask  = 4'b1000;
        wait_acks(1, 20, "t4_wait");
        step();
        chk("t4_err_cnt",  64'(obs_err.size()), 64'd1);
        chk("t4_err_idx",  64'(obs_err[0]), 64'd3);
        chk("t4_no_start", 64'(n_start - ns), 64'd0);
        size_cmd[1] = 32'd128;
        raise_mask  = 4'b0010;
        wait_acks(2, 20, "t4_wait2");
        chk("t4_next_idx", 64'(obs_ack[1]), 64'd1);
        drain("t4_drain");
        chk("t4_start", 64'(n_start - ns), 64'd1);

        // reset mid-transfer with engine still busy across release
        clear_logs();
        ns = n_start;
        size_cmd[0] = 32'd128;
        raise_mask  = 4'b0001;
        wait_acks(1, 20, "t5_wait");
        step();
        eng_hold = 1'b1;
        rst_cmd  = 1'b1;
        repeat (2) step();
        rst_cmd = 1'b0;
        size_cmd[2] = 32'd256;
        raise_mask  = 4'b0100;
        nd = n_good_done;
        base = n_start;
        repeat (6) step();
        chk("t5_no_start", 64'(n_start - base), 64'd0);
        chk("t5_no_done",  64'(n_good_done - nd), 64'd0);
        eng_hold = 1'b0;
        wait_acks(2, 30, "t5_wait2");
        chk("t5_idx", 64'(obs_ack[1]), 64'd2);
        drain("t5_drain");
        chk("t5_start", 64'(n_start - ns), 64'd2);

`ifdef AXI_B2AS_SCHED_STATS_EN
        // three good and one rejected transfer on bank 2
        do_reset();
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            size_cmd[2] = (i == 2) ? 32'd16 : 32'd256;
            raise_mask  = 4'b0100;
            wait_acks(i + 1, 40, "t6_wait");
            drain("t6_drain");
        end
        chk("t6_cnt2", 64'(o_xfer_cnt[2*32 +: 32]), 64'd3);
`endif

        // randomized traffic
        rnd_mode = 1'b1;
        repeat (3000) step();
        rnd_mode = 1'b0;
        drain("rnd_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
